// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage RISC-V pipeline: forwarding, load-use and long-op
// scoreboard stalls, branch flushes, and saturating stall/flush counters.
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_W-1:0]                Rs1D,
    input  logic [ADDR_W-1:0]                Rs2D,
    input  logic [ADDR_W-1:0]                RdD,
    input  logic                             LongD,
    input  logic [ADDR_W-1:0]                Rs1E,
    input  logic [ADDR_W-1:0]                Rs2E,
    input  logic [ADDR_W-1:0]                RdE,
    input  logic                             LongE,
    input  logic                             ResultSrcE0,
    input  logic                             PCSrcE,
    input  logic [ADDR_W-1:0]                RdM,
    input  logic [ADDR_W-1:0]                RdW,
    input  logic                             RegWriteM,
    input  logic                             RegWriteW,
    input  logic                             LongDoneW,
    input  logic [ADDR_W-1:0]                LongRdW,
    output logic                             StallF,
    output logic                             StallD,
    output logic                             FlushD,
    output logic                             FlushE,
    output logic [1:0]                       ForwardAE,
    output logic [1:0]                       ForwardBE,
    output logic [$clog2(MAX_PEND+1)-1:0]    PendCount,
    output logic [CNT_W-1:0]                 StallCnt,
    output logic [CNT_W-1:0]                 FlushCnt
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int PC_W = $clog2(MAX_PEND + 1);

    logic [NREG-1:0]  r_pend;
    logic [PC_W-1:0]  r_pend_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [NREG-1:0]  w_pend_next;
    logic             w_lw_stall;
    logic             w_sb_stall;
    logic             w_stall;
    logic             w_issue;
    logic             w_done;

    // Forwarding select for source A: M stage has priority over W stage
    always_comb begin
        ForwardAE = 2'b00;
        if ((Rs1E == RdM) && RegWriteM && (Rs1E != '0)) begin
            ForwardAE = 2'b10;
        end else if ((Rs1E == RdW) && RegWriteW && (Rs1E != '0)) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
    end

    // Forwarding select for source B: M stage has priority over W stage
    always_comb begin
        ForwardBE = 2'b00;
        if ((Rs2E == RdM) && RegWriteM && (Rs2E != '0)) begin
            ForwardBE = 2'b10;
        end else if ((Rs2E == RdW) && RegWriteW && (Rs2E != '0)) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // Stall and flush decisions from load-use and scoreboard hazards
    always_comb begin
        w_lw_stall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
        w_sb_stall = r_pend[Rs1D] || r_pend[Rs2D] || (r_pend[RdD] && (RdD != '0)) ||
                     (LongD && (r_pend_cnt == PC_W'(MAX_PEND)));
        w_stall    = w_lw_stall || w_sb_stall;
        StallF     = w_stall;
        StallD     = w_stall;
        FlushD     = PCSrcE;
        FlushE     = w_stall || PCSrcE;
    end

    // A completion only frees a slot if it names a pending register or the x0 slot
    always_comb begin
        w_issue     = LongE;
        w_done      = LongDoneW && ((LongRdW == '0) || r_pend[LongRdW]);
        w_pend_next = r_pend;
        if (LongDoneW && (LongRdW != '0)) begin
            w_pend_next[LongRdW] = 1'b0;
        end else begin
            w_pend_next = r_pend;
        end
        if (LongE && (RdE != '0)) begin
            w_pend_next[RdE] = 1'b1;
        end else begin
            w_pend_next[0] = 1'b0;
        end
    end

    // Pending-register bitmap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Long ops in flight; simultaneous issue and completion cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_cnt <= '0;
        end else if (w_issue && !w_done) begin
            if (r_pend_cnt != PC_W'(MAX_PEND)) begin
                r_pend_cnt <= r_pend_cnt + PC_W'(1);
            end
        end else if (w_done && !w_issue) begin
            if (r_pend_cnt != '0) begin
                r_pend_cnt <= r_pend_cnt - PC_W'(1);
            end
        end
    end

    // Saturating stall and flush performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (PCSrcE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign PendCount = r_pend_cnt;
    assign StallCnt  = r_stall_cnt;
    assign FlushCnt  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
    logic        LongD, LongE, ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, LongDoneW;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [2:0]  PendCount;
    logic [31:0] StallCnt, FlushCnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.ADDR_W(5), .MAX_PEND(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LongE(LongE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LongDoneW(LongDoneW), .LongRdW(LongRdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PendCount(PendCount), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; LongD = 1'b0;
        Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; LongE = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LongDoneW = 1'b0; LongRdW = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_pend", 32'(PendCount), 32'd0);
        chk("rst_stallcnt", StallCnt, 32'd0);
        chk("rst_flushcnt", FlushCnt, 32'd0);
        chk("rst_stall", 32'(StallF), 32'd0);
        rst_n = 1'b1;

        // Forwarding priority
        @(negedge clk); idle();
        Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1 chk("fwdA_M", 32'(ForwardAE), 32'd2);
        chk("fwdB_none", 32'(ForwardBE), 32'd0);
        RegWriteM = 1'b0;
        #1 chk("fwdA_W", 32'(ForwardAE), 32'd1);
        Rs1E = 5'd0;
        #1 chk("fwdA_x0", 32'(ForwardAE), 32'd0);
        Rs2E = 5'd6; RdW = 5'd6; RdM = 5'd5; RegWriteM = 1'b1;
        #1 chk("fwdB_W", 32'(ForwardBE), 32'd1);
        chk("fwd_nostall", 32'(StallF), 32'd0);

        // Load-use stall
        @(negedge clk); idle();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("lw_stallF", 32'(StallF), 32'd1);
        chk("lw_stallD", 32'(StallD), 32'd1);
        chk("lw_flushE", 32'(FlushE), 32'd1);
        chk("lw_flushD", 32'(FlushD), 32'd0);
        @(posedge clk); #1 chk("lw_stallcnt", StallCnt, 32'd1);
        @(negedge clk); idle();
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
        #1 chk("lw_rd0", 32'(StallF), 32'd0);
        @(posedge clk); #1 chk("lw_rd0_cnt", StallCnt, 32'd1);

        // Scoreboard RAW / WAW on x9
        @(negedge clk); idle();
        LongE = 1'b1; RdE = 5'd9;
        @(posedge clk); #1 chk("sb_pend1", 32'(PendCount), 32'd1);
        @(negedge clk); idle(); Rs1D = 5'd9;
        #1 chk("sb_raw", 32'(StallF), 32'd1);
        @(posedge clk); #1 chk("sb_raw_cnt", StallCnt, 32'd2);
        @(negedge clk); idle(); RdD = 5'd9;
        #1 chk("sb_waw", 32'(StallD), 32'd1);
        LongDoneW = 1'b1; LongRdW = 5'd9;
        #1 chk("sb_done_same", 32'(StallF), 32'd1);
        @(posedge clk); #1 chk("sb_pend0", 32'(PendCount), 32'd0);
        chk("sb_done_cnt", StallCnt, 32'd3);
        @(negedge clk); LongDoneW = 1'b0;
        #1 chk("sb_released", 32'(StallF), 32'd0);

        // Underflow of PendCount is ignored
        @(negedge clk); idle(); LongDoneW = 1'b1; LongRdW = 5'd0;
        @(posedge clk); #1 chk("underflow", 32'(PendCount), 32'd0);

        // Fill to MAX_PEND with x1..x4
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); idle(); LongE = 1'b1; RdE = 5'(k);
            @(posedge clk);
        end
        #1 chk("full_cnt", 32'(PendCount), 32'd4);
        @(negedge clk); idle(); LongD = 1'b1;
        #1 chk("full_stall", 32'(StallF), 32'd1);
        LongD = 1'b0;
        #1 chk("full_nolong", 32'(StallF), 32'd0);

        // Done x2 with issue x5 in the same cycle
        LongDoneW = 1'b1; LongRdW = 5'd2; LongE = 1'b1; RdE = 5'd5;
        @(posedge clk); #1 chk("swap_cnt", 32'(PendCount), 32'd4);
        @(negedge clk); idle(); Rs1D = 5'd5;
        #1 chk("swap_pend5", 32'(StallF), 32'd1);
        Rs1D = 5'd2;
        #1 chk("swap_pend2", 32'(StallF), 32'd0);

        // Issue and clear of x3 in the same cycle: set wins
        LongE = 1'b1; RdE = 5'd3; LongDoneW = 1'b1; LongRdW = 5'd3; Rs1D = 5'd0;
        @(posedge clk); #1 chk("setwin_cnt", 32'(PendCount), 32'd4);
        @(negedge clk); idle(); Rs1D = 5'd3;
        #1 chk("setwin_pend3", 32'(StallF), 32'd1);
        chk("stallcnt_hold", StallCnt, 32'd3);

        // Branch while scoreboard stalls
        PCSrcE = 1'b1;
        #1 chk("br_flushD", 32'(FlushD), 32'd1);
        chk("br_flushE", 32'(FlushE), 32'd1);
        @(posedge clk); #1 chk("br_flushcnt", FlushCnt, 32'd1);
        chk("br_stallcnt", StallCnt, 32'd4);

        // Retire x1 so three ops remain, then reset between edges
        @(negedge clk); idle(); LongDoneW = 1'b1; LongRdW = 5'd1;
        @(posedge clk); #1 chk("pre_rst_cnt", 32'(PendCount), 32'd3);
        @(negedge clk); idle(); Rs1D = 5'd3;
        #1 chk("pre_rst_stall", 32'(StallF), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("arst_pend", 32'(PendCount), 32'd0);
        chk("arst_stallcnt", StallCnt, 32'd0);
        chk("arst_flushcnt", FlushCnt, 32'd0);
        chk("arst_stall", 32'(StallF), 32'd0);
        rst_n = 1'b1;
        Rs1D = 5'd5;
        #1 chk("post_rst_x5", 32'(StallF), 32'd0);
        Rs1D = 5'd3;
        @(posedge clk); #1 chk("post_rst_cnt", 32'(PendCount), 32'd0);
        chk("post_rst_stall", 32'(StallF), 32'd0);
        chk("post_rst_stallcnt", StallCnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
